// File: rtl/alu_seq_ctrl_if.sv
// Request/response bus between the execute-stage issue logic and alu_seq_ctrl.
// The master is the issue side. The slave is the sequencer.
interface alu_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer in front of a 64-bit LEGv8 ALU.
// The sequencer holds one operation in flight. Single-pass ops use the ALU
// for one cycle. MUL iterates the ALU's ADD as a shift-add loop, examining
// MUL_ITERS multiplier bits LSB first.
// Optional feature: define ALU_SEQ_MUL_EARLY_EXIT_EN to end MUL as soon as
// no set multiplier bits remain. Results are identical with or without it.
module alu_seq_ctrl #(
  parameter int MUL_ITERS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_seq_ctrl_if.slave      bus,
  output logic        [63:0] alu_a,
  output logic        [63:0] alu_b,
  output logic        [3:0]  alu_ctl,
  input  logic        [63:0] alu_r
);

  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_PASS = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [63:0]        a_q, b_q;
  logic [63:0]        p_q, m_q, mq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        result_q;
  logic               zero_q, err_q;
  logic [63:0]        p_d;
  logic               mul_last;

  // Map the request opcode to the ALU control code (only used for ops 000-100).
  function automatic logic [3:0] alu_code(input logic [2:0] op);
    case (op)
      3'b000:  alu_code = CTL_AND;
      3'b001:  alu_code = CTL_OR;
      3'b010:  alu_code = CTL_ADD;
      3'b011:  alu_code = CTL_SUB;
      3'b100:  alu_code = CTL_PASS;
      default: alu_code = CTL_AND;
    endcase
  endfunction

  // Partial product update and loop termination for the current MUL iteration.
  always_comb begin
    p_d      = mq_q[0] ? alu_r : p_q;
    mul_last = (cnt_q == CNT_W'(MUL_ITERS - 1));
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    if ((mq_q >> 1) == 64'd0) mul_last = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op <= 3'b100)     state_d = S_EXEC;
          else if (bus.req_op == OP_MUL) state_d = S_MUL;
          else                           state_d = S_DONE;
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_MUL:   if (mul_last) state_d = S_DONE;
      S_DONE:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state: handshakes and ALU drive (zero when idle/done).
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.rsp_valid  = (state_q == S_DONE);
    bus.rsp_result = result_q;
    bus.rsp_zero   = zero_q;
    bus.rsp_err    = err_q;
    alu_a          = 64'd0;
    alu_b          = 64'd0;
    alu_ctl        = CTL_AND;
    case (state_q)
      S_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_ctl = alu_code(op_q);
      end
      S_MUL: begin
        alu_a   = p_q;
        alu_b   = m_q;
        alu_ctl = CTL_ADD;
      end
      default: ;
    endcase
  end

  // Operand latch, shift-add registers and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'd0;
      a_q      <= 64'd0;
      b_q      <= 64'd0;
      p_q      <= 64'd0;
      m_q      <= 64'd0;
      mq_q     <= 64'd0;
      cnt_q    <= '0;
      result_q <= 64'd0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q  <= bus.req_op;
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            p_q   <= 64'd0;
            m_q   <= bus.req_a;
            mq_q  <= bus.req_b;
            cnt_q <= '0;
            // Illegal opcodes answer immediately with a zero result.
            if (bus.req_op > OP_MUL) begin
              result_q <= 64'd0;
              zero_q   <= 1'b1;
              err_q    <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          result_q <= alu_r;
          zero_q   <= (alu_r == 64'd0);
          err_q    <= 1'b0;
        end
        S_MUL: begin
          p_q   <= p_d;
          m_q   <= m_q << 1;
          mq_q  <= mq_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            result_q <= p_d;
            zero_q   <= (p_d == 64'd0);
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed requests, a transaction-level model that
// predicts per-cycle outputs from op semantics and latency, and literal checks.
module tb_alu_seq_ctrl;

  localparam int MUL_ITERS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_ctl;

  always #5 clk = ~clk;

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.MUL_ITERS(MUL_ITERS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctl (alu_ctl),
    .alu_r   (alu_r)
  );

  // LEGv8 ALU stand-in.
  always_comb begin
    case (alu_ctl)
      4'b0000: alu_r = alu_a & alu_b;
      4'b0001: alu_r = alu_a | alu_b;
      4'b0010: alu_r = alu_a + alu_b;
      4'b0110: alu_r = alu_a - alu_b;
      4'b0111: alu_r = alu_b;
      default: alu_r = 64'd0;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state
  bit          busy = 0;
  int          acc_cyc = 0;
  int          lat = 0;
  logic [2:0]  m_op;
  logic [63:0] m_a, m_b, m_res;
  bit          m_err;
  int          n_rsp = 0;
  logic [63:0] last_res;
  logic        last_zero, last_err;
  int          last_lat = 0;
  int          k;
  bit          v_exp;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mask(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return b;
      3'd5: return a * (b & mask(MUL_ITERS));
      default: return 64'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [63:0] b);
    int l;
    if (op <= 3'd4) return 2;
    if (op != 3'd5) return 1;
    l = MUL_ITERS + 1;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    begin
      int hb;
      hb = 0;
      for (int i = 0; i < 64; i++) if (b[i]) hb = i;
      if (hb + 2 < l) l = hb + 2;
    end
`endif
    return l;
  endfunction

  function automatic logic [3:0] model_ctl(input logic [2:0] op);
    case (op)
      3'd0: return 4'b0000;
      3'd1: return 4'b0001;
      3'd2: return 4'b0010;
      3'd3: return 4'b0110;
      3'd4: return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // Compare process: check every cycle out of reset, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
    end else begin
      k = cyc - acc_cyc;
      v_exp = busy && (k >= lat);
      chk("req_ready", 64'(bus.req_ready), 64'(!busy));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(v_exp));
      if (v_exp) begin
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_zero", 64'(bus.rsp_zero), 64'(m_res == 64'd0));
        chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
      end
      if (busy && k < lat) begin
        chk("alu_ctl_busy", 64'(alu_ctl), 64'(model_ctl(m_op)));
        if (m_op == 3'd5) begin
          chk("mul_alu_a", alu_a, m_a * (m_b & mask(k - 1)));
          chk("mul_alu_b", alu_b, m_a << (k - 1));
        end else begin
          chk("exec_alu_a", alu_a, m_a);
          chk("exec_alu_b", alu_b, m_b);
        end
      end else begin
        chk("alu_ctl_idle", 64'(alu_ctl), 64'd0);
        chk("alu_ab_idle", alu_a | alu_b, 64'd0);
      end
      // Predict the coming edge.
      if (v_exp && bus.rsp_ready) begin
        last_res  = bus.rsp_result;
        last_zero = bus.rsp_zero;
        last_err  = bus.rsp_err;
        last_lat  = lat;
        n_rsp++;
        busy = 0;
      end else if (!busy && bus.req_valid) begin
        busy    = 1;
        acc_cyc = cyc;
        m_op    = bus.req_op;
        m_a     = bus.req_a;
        m_b     = bus.req_b;
        m_res   = model_result(bus.req_op, bus.req_a, bus.req_b);
        m_err   = (bus.req_op > 3'd5);
        lat     = model_lat(bus.req_op, bus.req_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int to;
    to = 0;
    while (!bus.req_ready && to < 300) begin step(); to++; end
    if (to >= 300) chk("issue_timeout", 64'(to), 64'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    step();
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 64'd0;
    bus.req_b     = 64'd0;
  endtask

  task automatic wait_rsp(input int n0);
    int to;
    to = 0;
    while (n_rsp == n0 && to < 300) begin step(); to++; end
    chk("rsp_timeout", 64'(n_rsp - n0), 64'd1);
  endtask

  int n0;
  int to;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 64'd0;
    bus.req_b     = 64'd0;
    bus.rsp_ready = 1'b1;

    #2;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_result", bus.rsp_result, 64'd0);
    chk("rst_zero", 64'(bus.rsp_zero), 64'd0);
    chk("rst_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_alu", alu_a | alu_b | 64'(alu_ctl), 64'd0);
    #10 rst_n = 1'b1;
    step(); step();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // ADD 5+7
    n0 = n_rsp;
    issue(3'd2, 64'd5, 64'd7);
    chk("add_ctl_c1", 64'(alu_ctl), 64'h2);
    wait_rsp(n0);
    chk("add_res", last_res, 64'd12);
    chk("add_zero", 64'(last_zero), 64'd0);
    chk("add_err", 64'(last_err), 64'd0);
    chk("add_lat", 64'(last_lat), 64'd2);

    // SUB 3-3, then 0-1
    n0 = n_rsp; issue(3'd3, 64'd3, 64'd3); wait_rsp(n0);
    chk("sub_zero_res", last_res, 64'd0);
    chk("sub_zero_flag", 64'(last_zero), 64'd1);
    n0 = n_rsp; issue(3'd3, 64'd0, 64'd1); wait_rsp(n0);
    chk("sub_wrap_res", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_wrap_zero", 64'(last_zero), 64'd0);

    // AND / OR / PASSB
    n0 = n_rsp; issue(3'd0, 64'hF0F0, 64'h3C3C); wait_rsp(n0);
    chk("and_res", last_res, 64'h3030);
    n0 = n_rsp; issue(3'd1, 64'hF000, 64'h000F); wait_rsp(n0);
    chk("or_res", last_res, 64'hF00F);
    n0 = n_rsp; issue(3'd4, 64'hAAAA, 64'h5555); wait_rsp(n0);
    chk("passb_res", last_res, 64'h5555);

    // MUL 0x1234 * 0x10
    n0 = n_rsp; issue(3'd5, 64'h1234, 64'h10); wait_rsp(n0);
    chk("mul_res", last_res, 64'h12340);
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    chk("mul_lat", 64'(last_lat), 64'd6);
`else
    chk("mul_lat", 64'(last_lat), 64'd65);
`endif

    // MUL all-ones * 2: upper bits discarded
    n0 = n_rsp; issue(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2); wait_rsp(n0);
    chk("mul_wrap_res", last_res, 64'hFFFF_FFFF_FFFF_FFFE);

    // MUL by zero
    n0 = n_rsp; issue(3'd5, 64'd77, 64'd0); wait_rsp(n0);
    chk("mul_b0_res", last_res, 64'd0);
    chk("mul_b0_zero", 64'(last_zero), 64'd1);

    // Illegal op 111
    n0 = n_rsp; issue(3'd7, 64'd1, 64'd1);
    chk("ill_ctl_c1", 64'(alu_ctl), 64'd0);
    wait_rsp(n0);
    chk("ill_res", last_res, 64'd0);
    chk("ill_err", 64'(last_err), 64'd1);
    chk("ill_lat", 64'(last_lat), 64'd1);

    // Backpressure: hold rsp_ready low, a second request must be ignored
    bus.rsp_ready = 1'b0;
    n0 = n_rsp;
    issue(3'd2, 64'd1, 64'd1);
    to = 0;
    while (!bus.rsp_valid && to < 50) begin step(); to++; end
    chk("bp_valid_seen", 64'(bus.rsp_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd3;
      bus.req_a     = 64'd9;
      bus.req_b     = 64'd4;
      chk("bp_hold_result", bus.rsp_result, 64'd2);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      step();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_handshake", 64'(n_rsp - n0), 64'd1);
    chk("bp_res", last_res, 64'd2);

    // Reset during MUL iteration 10
    n0 = n_rsp;
    issue(3'd5, 64'd3, 64'hFFFF);
    repeat (9) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mrst_result", bus.rsp_result, 64'd0);
    chk("mrst_flags", 64'({bus.rsp_zero, bus.rsp_err}), 64'd0);
    chk("mrst_alu", alu_a | alu_b | 64'(alu_ctl), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (80) step();
    chk("mrst_no_rsp", 64'(n_rsp - n0), 64'd0);

    // Still functional after reset
    n0 = n_rsp; issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); wait_rsp(n0);
    chk("post_rst_add", last_res, 64'd0);
    chk("post_rst_zero", 64'(last_zero), 64'd1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer in front of the 64-bit LEGv8 ALU: accepts one operation per valid/ready request, drives the ALU operands/control, and returns a registered result plus zero and error flags.
- Single-pass ops (AND, OR, ADD, SUB, PASS-B) use the ALU for one cycle.
- MUL is built by iterating the ALU's ADD op as a shift-add loop.
- Sits between the execute-stage issue logic and the ALU instance.

Parameters:
- MUL_ITERS, 64, number of shift-add iterations for MUL (multiplier bits examined, LSB first; 1..64).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 PASSB, 101 MUL, 110/111 illegal.
- req_a  in  64  operand A.
- req_b  in  64  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_result  out  64  registered result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_err  out  1  illegal opcode.
- alu_a  out  64  ALU input A.
- alu_b  out  64  ALU input B.
- alu_ctl  out  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASSB.
- alu_r  in  64  ALU result (combinational from alu_a/alu_b/alu_ctl).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1 after release; rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0; alu_a=alu_b=0, alu_ctl=0000; internal P/M/Q/count=0.
- Reset mid-operation abandons the operation with no response.
- States:
  - IDLE: req_ready=1. On req_valid, latch op/A/B. For ops 000-100, go to EXEC. For MUL, go to MUL with P=0, M=req_a, Q=req_b, count=0. For illegal ops, go to DONE with result=0 and err=1.
  - EXEC (1 cycle): alu_a=A, alu_b=B, alu_ctl=mapped code. Register alu_r into rsp_result, then go to DONE.
  - MUL (1 cycle per iteration): alu_a=P, alu_b=M, alu_ctl=0010.
    - If Q[0]=1, P<=alu_r; else P unchanged.
    - Then M<=M<<1, Q<=Q>>1, count++.
    - Go to DONE when count==MUL_ITERS-1, with rsp_result = final P.
  - DONE: rsp_valid=1, with result/zero/err stable. On rsp_ready, go to IDLE with rsp_valid deasserted next cycle.
- req_ready is 1 only in IDLE; req_ready=0 in EXEC/MUL/DONE.
- No request is accepted in the same cycle a response handshakes. This gives one request in flight.
- alu_a/alu_b/alu_ctl are 0/0/0000 in IDLE and DONE.
- Latency, from the accept edge (cycle 0):
  - single-pass op: rsp_valid in cycle 2;
  - illegal op: rsp_valid in cycle 1;
  - MUL: rsp_valid in cycle MUL_ITERS+1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^64, with no carry/overflow output.
  - MUL returns the low 64 bits of A*B restricted to the low MUL_ITERS bits of B. Upper bits are discarded.
- rsp_zero is registered with rsp_result and is computed from the result, not from the operands.
- Request inputs are ignored outside IDLE. Latched operands are unaffected by later req_* changes.
- Counter width is clog2(MUL_ITERS) bits, minimum 1.

Optional Feature:
- Macro: ALU_SEQ_MUL_EARLY_EXIT_EN.
- Defined: in MUL, also go to DONE when (Q>>1)==0 after the current iteration. MUL latency becomes (index of the highest set bit of B)+2 cycles. B==0 gives rsp_valid in cycle 2 with result 0.
- Undefined: MUL always takes MUL_ITERS iterations.
- Results are identical either way.

Test Plan:
- ADD A=5, B=7, rsp_ready=1 -> alu_ctl=0010 in cycle 1; rsp_valid in cycle 2 with result 12, zero=0, err=0; req_ready back to 1 in cycle 3.
- SUB A=3, B=3 -> result 0, zero=1. Then SUB A=0, B=1 -> result 0xFFFF_FFFF_FFFF_FFFF (wrap), zero=0.
- MUL A=0x1234, B=0x10, default params:
  - without the macro -> rsp_valid in cycle 65, result 0x12340;
  - with ALU_SEQ_MUL_EARLY_EXIT_EN -> rsp_valid in cycle 6, same result.
- MUL A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> result 0xFFFF_FFFF_FFFF_FFFE (upper bits discarded).
- Illegal op 111 with A=B=1 -> rsp_valid in cycle 1, result 0, err=1; alu_ctl stays 0000 throughout.
- Backpressure and reset:
  - hold rsp_ready=0 for 3 cycles after ADD 1+1 -> result 2 stays stable; req_ready=0 and a second req_valid is ignored; the handshake completes on rsp_ready=1.
  - assert rst_n=0 during MUL iteration 10 -> all outputs return to reset values immediately; no rsp_valid after release.
